// File: rtl/fir_buf_wr.sv
// Write-side address generator for the banked FIR sample RAM: round-robin bank
// distribution, registered RAM write port and occupancy tracking against the reader.
module fir_buf_wr #(
  parameter int DW = 16,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          r,
  input  logic          mode,
  input  logic          clr,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic          rd_en,
  output logic          wr_en,
  output logic [1:0]    wr_bank,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic [AW+2:0] level,
  output logic          full,
  output logic          empty,
  output logic          ovf,
  output logic          udf,
  output logic [1:0]    dbg_state
);

  // Handshake: a sample transfers on every rising edge where in_valid && in_ready;
  // in_ready depends only on registered state, and in_data is captured at that edge.

  localparam int LW = AW + 3;
  localparam logic [LW-1:0] CAP3 = LW'(3 * (2 ** AW));
  localparam logic [LW-1:0] CAP4 = LW'(4 * (2 ** AW));

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FILL  = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   level_q, level_d;
  logic [1:0]      bank_q, bank_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            wr_en_q;
  logic [1:0]      wr_bank_q;
  logic [AW-1:0]   wr_addr_q;
  logic [DW-1:0]   wr_data_q;
  logic            ovf_q, udf_q;
  logic            mode_q;
  logic            rst_hold_q;
  logic            accept, drain;
  logic [LW-1:0]   cap;
  logic [1:0]      last_bank;

  assign in_ready = (state_q != S_FULL);

  always_comb begin
    accept    = in_valid && in_ready;
    drain     = rd_en && (state_q != S_EMPTY);
    cap       = mode_q ? CAP3 : CAP4;
    last_bank = mode_q ? 2'd2 : 2'd3;

    level_d = level_q;
    if (accept && !drain) begin
      level_d = level_q + 1'b1;
    end else if (!accept && drain) begin
      level_d = level_q - 1'b1;
    end

    // '>=' also recovers a pointer left on bank 3 when the buffer drained in
    // 4-bank mode and was then switched to 3 banks.
    bank_d = bank_q;
    addr_d = addr_q;
    if (accept) begin
      if (bank_q >= last_bank) begin
        bank_d = 2'd0;
        addr_d = addr_q + 1'b1;
      end else begin
        bank_d = bank_q + 2'd1;
      end
    end

    state_d = state_q;
    case (state_q)
      S_EMPTY: if (accept) state_d = S_FILL;
      S_FILL: begin
        if (level_d == cap)     state_d = S_FULL;
        else if (level_d == '0) state_d = S_EMPTY;
      end
      S_FULL:  if (drain) state_d = S_FILL;
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state_q   <= S_EMPTY;
      level_q   <= '0;
      bank_q    <= '0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_bank_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else if (clr) begin
      state_q   <= S_EMPTY;
      level_q   <= '0;
      bank_q    <= '0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_bank_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      bank_q  <= bank_d;
      addr_q  <= addr_d;
      wr_en_q <= accept;
      if (accept) begin
        wr_bank_q <= bank_q;
        wr_addr_q <= addr_q;
        wr_data_q <= in_data;
      end
      if (in_valid && !in_ready)         ovf_q <= 1'b1;
      if (rd_en && state_q == S_EMPTY)   udf_q <= 1'b1;
    end
  end

  // Remembers that reset was seen so the mode flop can sample mode without
  // using the asynchronous reset net as a synchronous term.
  always_ff @(posedge clk or negedge r) begin
    if (!r) rst_hold_q <= 1'b1;
    else    rst_hold_q <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst_hold_q || clr || (state_q == S_EMPTY && !accept)) begin
      mode_q <= mode;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_bank   = wr_bank_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign level     = level_q;
  assign full      = (state_q == S_FULL);
  assign empty     = (state_q == S_EMPTY);
  assign ovf       = ovf_q;
  assign udf       = udf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fir_buf_wr.sv
// Randomized bench for fir_buf_wr against an occupancy/pointer model built from
// the buffer's rules, with a write-data scoreboard queue.
module tb_fir_buf_wr;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          r = 1'b0;
  logic          mode = 1'b1;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          rd_en = 1'b0;
  logic          wr_en;
  logic [1:0]    wr_bank;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW+2:0] level;
  logic          full, empty, ovf, udf;
  logic [1:0]    dbg_state;

  fir_buf_wr #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .r(r), .mode(mode), .clr(clr),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .rd_en(rd_en), .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .wr_data(wr_data), .level(level), .full(full), .empty(empty),
    .ovf(ovf), .udf(udf), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model state
  int            m_level, m_bank, m_addr, m_acc_cnt;
  bit            m_mode, m_ovf, m_udf, e_wr_en;
  int            e_bank, e_addr;
  logic [DW-1:0] m_data;
  logic [DW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_fail = 0;

  function automatic int cap_m();
    return (m_mode ? 3 : 4) * DEPTH;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_level = 0; m_bank = 0; m_addr = 0;
    m_ovf = 0; m_udf = 0; e_wr_en = 0;
    e_bank = 0; e_addr = 0; m_data = '0;
    m_mode = mode;
    exp_q.delete();
  endtask

  task automatic check_all();
    check("wr_en", 32'(wr_en), 32'(e_wr_en));
    if (wr_en) begin
      if (exp_q.size() == 0) check("wr_unexpected", 32'(wr_en), 32'd0);
      else check("wr_data_sb", 32'(wr_data), 32'(exp_q.pop_front()));
    end
    check("wr_data", 32'(wr_data), 32'(m_data));
    check("wr_bank", 32'(wr_bank), 32'(e_bank));
    check("wr_addr", 32'(wr_addr), 32'(e_addr));
    check("level", 32'(level), 32'(m_level));
    check("full", 32'(full), 32'(m_level == cap_m()));
    check("empty", 32'(empty), 32'(m_level == 0));
    check("in_ready", 32'(in_ready), 32'(m_level != cap_m()));
    check("ovf", 32'(ovf), 32'(m_ovf));
    check("udf", 32'(udf), 32'(m_udf));
  endtask

  // driver: one clock of stimulus, model update after the edge, then check
  task automatic step(input bit v, input logic [DW-1:0] d, input bit rd, input bit c);
    bit acc, dec, was_empty;
    int nb;
    in_valid = v; in_data = d; rd_en = rd; clr = c;
    acc = v && (m_level != cap_m());
    dec = rd && (m_level > 0);
    was_empty = (m_level == 0);
    @(posedge clk);
    #1;
    if (c) begin
      model_reset();
    end else begin
      e_wr_en = acc;
      if (acc) begin
        exp_q.push_back(d);
        e_bank = m_bank; e_addr = m_addr; m_data = d;
        m_acc_cnt++;
        nb = m_mode ? 3 : 4;
        if (m_bank >= nb - 1) begin
          m_bank = 0;
          m_addr = (m_addr + 1) % DEPTH;
        end else begin
          m_bank = m_bank + 1;
        end
      end
      if (rd && !dec) m_udf = 1;
      if (v && !acc)  m_ovf = 1;
      m_level = m_level + int'(acc) - int'(dec);
      if (was_empty && !acc) m_mode = mode;
    end
    in_valid = 0; rd_en = 0; clr = 0;
    check_all();
  endtask

  function automatic logic [DW-1:0] rnd();
    return DW'($urandom_range(0, 65535));
  endfunction

  initial begin
    // reset with mode=1
    mode = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    check_all();
    r = 1'b1;

    // mode 1: seven back-to-back samples 1..7
    for (int i = 1; i <= 7; i++) step(1, DW'(i), 0, 0);
    step(0, '0, 0, 0);
    check("level_after_7", 32'(level), 32'd7);

    // mode 0: fill to capacity, overflow attempts, then one read
    mode = 1'b0;
    step(0, '0, 0, 1);
    for (int i = 0; i < 4 * DEPTH; i++) step(1, rnd(), 0, 0);
    for (int i = 0; i < 3; i++) step(1, rnd(), 0, 0);
    step(1, rnd(), 1, 0);
    step(0, '0, 0, 0);
    check("level_after_read", 32'(level), 32'(4 * DEPTH - 1));

    // mode 1: pointer wrap with random reads keeping the buffer below capacity
    mode = 1'b1;
    step(0, '0, 0, 1);
    m_acc_cnt = 0;
    for (int i = 0; i < 9000 && m_acc_cnt < 3 * DEPTH + 50; i++)
      step($urandom_range(0, 3) != 0, rnd(), $urandom_range(0, 1) == 1, 0);
    check("wrap_reached", 32'(m_acc_cnt >= 3 * DEPTH + 50), 32'd1);

    // accept and read together at level 5
    step(0, '0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, rnd(), 0, 0);
    step(1, rnd(), 1, 0);
    check("level_simul", 32'(level), 32'd5);

    // drain, underflow, clear
    for (int i = 0; i < 5; i++) step(0, '0, 1, 0);
    step(0, '0, 1, 0);
    step(0, '0, 0, 1);

    // mode change while occupied is deferred until drained
    mode = 1'b0;
    step(0, '0, 0, 1);
    step(1, rnd(), 0, 0);
    step(1, rnd(), 0, 0);
    mode = 1'b1;
    for (int i = 0; i < 3; i++) step(1, rnd(), 0, 0);
    for (int i = 0; i < 5; i++) step(0, '0, 1, 0);
    step(0, '0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, rnd(), 0, 0);

    // random mixed traffic with occasional mode changes and clears
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      step($urandom_range(0, 1) == 1, rnd(), $urandom_range(0, 2) == 0,
           $urandom_range(0, 199) == 0);
    end

    // asynchronous reset mid-burst at level 37
    step(0, '0, 0, 1);
    for (int i = 0; i < 37; i++) step(1, rnd(), 0, 0);
    in_valid = 1'b1; in_data = rnd();
    #2;
    r = 1'b0;
    #1;
    model_reset();
    check_all();
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    r = 1'b1;
    step(1, rnd(), 0, 0);
    check("first_bank", 32'(wr_bank), 32'd0);
    check("first_addr", 32'(wr_addr), 32'd0);
    for (int i = 0; i < 4; i++) step(1, rnd(), $urandom_range(0, 1) == 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
